// File: rtl/leaky_relu_backward.sv
// Leaky ReLU backward pass: caches forward pre-activations in a FIFO and gates each gradient by
// the sign of its cached value. Define LEAKY_RELU_BACKWARD_SATURATE_EN to clamp the leak product.
module leaky_relu_backward #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            leak_factor,
  input  logic                   fwd_valid_in,
  input  logic [15:0]            fwd_z_in,
  input  logic                   grad_valid_in,
  input  logic [15:0]            grad_in,
  output logic                   grad_ready_out,
  output logic [15:0]            grad_out,
  output logic                   grad_valid_out,
  input  logic                   grad_ready_in,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [15:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        grad_out_q, grad_out_d;
  logic               grad_valid_q, grad_valid_d;

  logic               empty, full;
  logic               pop, push, push_drop;
  logic [15:0]        head_z;
  logic               head_pos;
  logic signed [31:0] grad_ext, leak_ext;
  logic signed [31:0] product, shifted;
  logic [15:0]        leak_result, result;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  // Ready only with a cached value to pair against and room in the output register.
  assign grad_ready_out = !empty && (!grad_valid_q || grad_ready_in);
  assign pop            = grad_valid_in && grad_ready_out;
  // A simultaneous pop frees the slot, so a push into a full cache still lands.
  assign push           = fwd_valid_in && (!full || pop);
  assign push_drop      = fwd_valid_in && full && !pop;

  assign head_z   = mem_q[rd_ptr_q];
  // Strict > 0: zero takes the leak path, matching the forward activation.
  assign head_pos = !head_z[15] && (head_z != '0);

  assign grad_ext = {{16{grad_in[15]}}, grad_in};
  assign leak_ext = {{16{leak_factor[15]}}, leak_factor};
  assign product  = grad_ext * leak_ext;
  assign shifted  = product >>> FRAC_BITS;

`ifdef LEAKY_RELU_BACKWARD_SATURATE_EN
  always_comb begin
    if (shifted > 32'sd32767) begin
      leak_result = 16'h7fff;
    end else if (shifted < -32'sd32768) begin
      leak_result = 16'h8000;
    end else begin
      leak_result = shifted[15:0];
    end
  end
`else
  assign leak_result = shifted[15:0];
`endif

  assign result = head_pos ? grad_in : leak_result;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    grad_out_d   = grad_out_q;
    grad_valid_d = grad_valid_q;
    if (flush) begin
      // grad_out deliberately keeps its last value.
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      grad_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push_drop) begin
        overflow_d = 1'b1;
      end
      if (pop) begin
        grad_out_d   = result;
        grad_valid_d = 1'b1;
      end else if (grad_ready_in) begin
        grad_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= fwd_z_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      grad_out_q   <= '0;
      grad_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      grad_out_q   <= grad_out_d;
      grad_valid_q <= grad_valid_d;
    end
  end

  assign grad_out       = grad_out_q;
  assign grad_valid_out = grad_valid_q;
  assign count          = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_leaky_relu_backward.sv
// Scoreboard bench for leaky_relu_backward: a queue-based model tracks the cache and predicts
// each gradient result; a separate monitor compares every presented output.
module tb_leaky_relu_backward;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int          FRAC  = 8;
`ifdef LEAKY_RELU_BACKWARD_SATURATE_EN
  localparam logic [15:0] SatExp = 16'h7fff;
`else
  localparam logic [15:0] SatExp = 16'hfffe;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] leak_factor = '0;
  logic        fwd_valid_in = 1'b0;
  logic [15:0] fwd_z_in = '0;
  logic        grad_valid_in = 1'b0;
  logic [15:0] grad_in = '0;
  logic        grad_ready_out;
  logic [15:0] grad_out;
  logic        grad_valid_out;
  logic        grad_ready_in = 1'b1;
  logic        flush = 1'b0;
  logic [AW:0] count;
  logic        overflow;

  leaky_relu_backward #(.DEPTH(DEPTH), .FRAC_BITS(FRAC)) dut (
    .clk           (clk),
    .rst           (rst),
    .leak_factor   (leak_factor),
    .fwd_valid_in  (fwd_valid_in),
    .fwd_z_in      (fwd_z_in),
    .grad_valid_in (grad_valid_in),
    .grad_in       (grad_in),
    .grad_ready_out(grad_ready_out),
    .grad_out      (grad_out),
    .grad_valid_out(grad_valid_out),
    .grad_ready_in (grad_ready_in),
    .flush         (flush),
    .count         (count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] z_model[$];
  logic [15:0] exp_q[$];
  logic        m_valid = 1'b0;
  logic        m_ovf   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // dL/dz from the activation rule, using plain integer arithmetic.
  function automatic logic [15:0] ref_grad(input logic [15:0] z, input logic [15:0] g,
                                           input logic [15:0] leak);
    int p;
    if ($signed(z) > 0) return g;
    p = int'($signed(g)) * int'($signed(leak));
    p = p >>> FRAC;
`ifdef LEAKY_RELU_BACKWARD_SATURATE_EN
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
`endif
    return p[15:0];
  endfunction

  // Model: mid-cycle, check state then advance to what the coming edge should produce.
  initial forever begin
    logic exp_ready, pop, was_full;
    @(negedge clk);
    #2;
    if (!rst) begin
      z_model.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      exp_ready = (z_model.size() != 0) && (!m_valid || grad_ready_in);
      check("count", 32'(count), z_model.size());
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("grad_valid_out", 32'(grad_valid_out), 32'(m_valid));
      check("grad_ready_out", 32'(grad_ready_out), 32'(exp_ready));
      if (flush) begin
        z_model.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_ovf   = 1'b0;
      end else begin
        pop      = grad_valid_in && exp_ready;
        was_full = (z_model.size() == DEPTH);
        if (pop) exp_q.push_back(ref_grad(z_model.pop_front(), grad_in, leak_factor));
        if (fwd_valid_in) begin
          if (!was_full || pop) z_model.push_back(fwd_z_in);
          else m_ovf = 1'b1;
        end
        if (pop) m_valid = 1'b1;
        else if (grad_ready_in) m_valid = 1'b0;
      end
    end
  end

  // Monitor: every presented result must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst && grad_valid_out) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h want none at %0t", grad_out, $time);
      end else begin
        check("grad_out", 32'(grad_out), 32'(exp_q[0]));
        if (grad_ready_in) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fwd_valid_in  = 1'b0;
    grad_valid_in = 1'b0;
    flush         = 1'b0;
    grad_ready_in = 1'b1;
  endtask

  task automatic push_n(input int n);
    fwd_valid_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      fwd_z_in = 16'($urandom());
      step();
    end
    fwd_valid_in = 1'b0;
  endtask

  initial begin
    idle();
    #1 rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(grad_valid_out), 0);
    check("rst_grad_out", 32'(grad_out), 0);
    check("rst_overflow", 32'(overflow), 0);
    step();
    step();
    rst = 1'b1;
    step();

    // Pass-through then leak.
    leak_factor  = 16'h0040;
    fwd_valid_in = 1'b1;
    fwd_z_in     = 16'h0100;
    step();
    fwd_z_in = 16'hff00;
    step();
    fwd_valid_in  = 1'b0;
    grad_valid_in = 1'b1;
    grad_in       = 16'h0200;
    step();
    step();
    grad_valid_in = 1'b0;
    step();
    step();

    // Zero takes the leak path; gradient with empty cache stalls.
    fwd_valid_in = 1'b1;
    fwd_z_in     = 16'h0000;
    step();
    fwd_valid_in  = 1'b0;
    grad_valid_in = 1'b1;
    grad_in       = 16'h0400;
    step();
    step();
    step();
    idle();
    step();
    step();

    // Backpressure with a pending result, then a 4-result stream.
    grad_ready_in = 1'b0;
    push_n(5);
    grad_valid_in = 1'b1;
    grad_in       = 16'($urandom());
    step();
    repeat (3) step();
    grad_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      grad_in = 16'($urandom());
      step();
    end
    idle();
    step();
    step();

    // Overflow, ordered drain, then concurrent push/pop across the wrap.
    push_n(17);
    grad_valid_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      grad_in = 16'($urandom());
      step();
    end
    fwd_valid_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fwd_z_in = 16'($urandom());
      grad_in  = 16'($urandom());
      step();
    end
    fwd_valid_in = 1'b0;
    step();
    step();
    idle();
    step();

    // Saturation corner of the leak product.
    leak_factor  = 16'h0200;
    fwd_valid_in = 1'b1;
    fwd_z_in     = 16'h8000;
    step();
    fwd_valid_in  = 1'b0;
    grad_valid_in = 1'b1;
    grad_in       = 16'h7fff;
    step();
    grad_valid_in = 1'b0;
    check("sat_grad_out", 32'(grad_out), 32'(SatExp));
    step();
    step();

    // Flush with five cached values and a held output.
    grad_ready_in = 1'b0;
    push_n(6);
    grad_valid_in = 1'b1;
    grad_in       = 16'($urandom());
    step();
    grad_valid_in = 1'b0;
    flush         = 1'b1;
    step();
    flush = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(grad_valid_out), 0);
    check("flush_overflow", 32'(overflow), 0);
    idle();
    step();
    step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) leak_factor = 16'($urandom());
      fwd_valid_in  = ($urandom_range(0, 1) == 1);
      fwd_z_in      = 16'($urandom());
      grad_valid_in = ($urandom_range(0, 9) < 6);
      grad_in       = 16'($urandom());
      grad_ready_in = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 99) == 0);
      if (flush) grad_ready_in = 1'b0;
      step();
    end
    idle();
    step();
    step();

    // Asynchronous reset mid-stream.
    grad_ready_in = 1'b0;
    push_n(4);
    grad_valid_in = 1'b1;
    grad_in       = 16'($urandom());
    fwd_valid_in  = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_valid", 32'(grad_valid_out), 0);
    check("arst_grad_out", 32'(grad_out), 0);
    check("arst_overflow", 32'(overflow), 0);
    check("arst_ready", 32'(grad_ready_out), 0);
    idle();
    step();
    step();
    rst = 1'b1;
    step();
    leak_factor = 16'h0080;
    push_n(2);
    grad_valid_in = 1'b1;
    grad_in       = 16'h1234;
    step();
    step();
    idle();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaky_relu_backward.md
Name: leaky_relu_backward

Overview:
- Backward-pass counterpart of the leaky ReLU activation: during the forward pass it caches each pre-activation value in a FIFO.
- During backprop it pops one cached value per incoming gradient and emits dL/dz. The gradient passes through unchanged when the cached value is > 0; otherwise it is multiplied by leak_factor.
- Sits between the systolic array's gradient output and the weight-update path. Data is Q8.8 signed fixed point throughout.

Parameters:
- DEPTH, 16, number of cached pre-activations; must be a power of two, >= 2.
- FRAC_BITS, 8, fractional bits of the fixed-point format.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- leak_factor  in  16  signed Q8.8 leak slope; must be held stable during backward pass
- fwd_valid_in  in  1  pre-activation present this cycle (push strobe)
- fwd_z_in  in  16  signed pre-activation value to cache
- grad_valid_in  in  1  incoming gradient valid
- grad_in  in  16  signed incoming gradient dL/da
- grad_ready_out  out  1  gradient accepted when grad_valid_in && grad_ready_out
- grad_out  out  16  signed dL/dz
- grad_valid_out  out  1  grad_out valid
- grad_ready_in  in  1  downstream ready
- flush  in  1  synchronous clear of cache and output stage
- count  out  $clog2(DEPTH)+1  entries currently cached
- overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (rst low, async): FIFO pointers and count = 0; grad_out = 0; grad_valid_out = 0; overflow = 0.
- Cache is a FIFO: gradients consume pre-activations in the same order the pre-activations were pushed.
- Push: when fwd_valid_in = 1 and the FIFO is not full, write fwd_z_in and increment count.
- Push while full is dropped and sets overflow. Exception: if a pop occurs in the same cycle, the push is accepted and count is unchanged.
- Output stage: a single register.
  - grad_ready_out = (count != 0) && (!grad_valid_out || grad_ready_in).
  - grad_ready_out is never asserted when the cache is empty.
- Accept (grad_valid_in && grad_ready_out):
  - pop the head value z;
  - next cycle, grad_out = (z > 0) ? grad_in : mul(grad_in, leak_factor), and grad_valid_out = 1.
  - Latency is 1 cycle. One result per cycle sustained while grad_ready_in = 1.
- z == 0 takes the leak path (strict > 0 test, matching the forward activation).
- grad_valid_out / grad_out hold steady while grad_ready_in = 0. grad_valid_out clears after a handshake unless a new accept occurs in the same cycle.
- mul: full 32-bit signed product, arithmetic shift right by FRAC_BITS, then reduce to 16 bits per the optional feature.
- Simultaneous push and pop on an empty FIFO: the pop is not possible because grad_ready_out = 0; the push completes normally.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- flush (synchronous, wins over push/pop in the same cycle): count = 0, pointers = 0, grad_valid_out = 0, overflow = 0. grad_out keeps its value.
- Reset mid-transfer: all in-flight data is discarded immediately; no output is produced for accepted-but-not-yet-output gradients.

Optional Feature:
- Macro: LEAKY_RELU_BACKWARD_SATURATE_EN.
- Defined: the shifted product is clamped to [0x8000, 0x7FFF].
- Undefined: the low 16 bits of the shifted product are taken (two's-complement wrap).

Test Plan:
- Pass-through and leak: reset, leak = 0x0040 (0.25), push z = 0x0100 then z = 0xFF00, send grad 0x0200 twice.
  -> grad_out 0x0200, then 0x0080, each 1 cycle after accept; count 2 -> 1 -> 0.
- Zero boundary and empty stall: push z = 0x0000, grad 0x0400 -> grad_out 0x0100. A second grad_valid_in with count = 0 -> grad_ready_out stays 0 and no output.
- Backpressure: grad_ready_in low 3 cycles with a result pending -> grad_out/grad_valid_out stable and grad_ready_out = 0. Release -> stream of 4 results at 1 per cycle.
- Overflow and wrap: DEPTH = 16, push 17 values -> count = 16 and overflow = 1. Pop all 16 -> outputs match the first 16 pushes in order. Then push/pop 20 more across wrap -> order preserved.
- Saturation: leak = 0x0200, push z = 0x8000, grad 0x7FFF.
  -> grad_out 0x7FFF with the macro; 0xFFFE without it.
- Flush and async reset: with count = 5 and a pending output:
  - flush -> count 0, grad_valid_out 0, overflow 0 on the next edge;
  - separately, rst low mid-stream -> all outputs 0 without waiting for a clock edge.
